// File: rtl/sdram_cmd_queue.sv
// sdram_cmd_queue
// Command front-end for port 0 of the sdram controller. Client read/write
// commands arrive on a valid/ready stream and are buffered in a DEPTH-entry
// FIFO. They are issued one at a time on the controller's level-held
// p0_* request/ready handshake. Read data returns as a one-cycle rsp_valid
// pulse.
//
// Ports
//   clk, reset     : single clock; synchronous active-high reset
//   init_complete  : controller finished init; nothing is issued before it
//   cmd_valid/ready: client command handshake (push on valid && ready)
//   cmd_we/addr/data/byte_en : command fields (data ignored for reads)
//   rsp_valid      : one-cycle pulse when a read completes
//   rsp_data       : last read data, held until the next read completes
//   level          : FIFO occupancy
//   p0_addr/data/byte_en : registered request fields, zero when no strobe
//   p0_wr_req/rd_req     : request strobes, mutually exclusive
//   p0_ready       : controller idle / operation complete
//   p0_q           : controller read data
module sdram_cmd_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_complete,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data,
    input  logic [3:0]                cmd_byte_en,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic [ADDR_WIDTH-1:0]     p0_addr,
    output logic [DATA_WIDTH-1:0]     p0_data,
    output logic [3:0]                p0_byte_en,
    output logic                      p0_wr_req,
    output logic                      p0_rd_req,
    input  logic                      p0_ready,
    input  logic [DATA_WIDTH-1:0]     p0_q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t state, state_nxt;

    // FIFO storage carries no reset; only pointers and count do.
    logic                  fifo_we      [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr    [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data    [DEPTH];
    logic [3:0]            fifo_byte_en [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic issue;
    logic done;
    logic start_ok;
    logic is_read;

    // Full is taken from the registered count only, so a pop in the same
    // cycle never lets a push through a full FIFO.
    assign full      = (count == LVL_W'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign level     = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are PTR_W bits wide, so wrap modulo DEPTH is implicit.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]      <= cmd_we;
            fifo_addr[wr_ptr]    <= cmd_addr;
            fifo_data[wr_ptr]    <= cmd_data;
            fifo_byte_en[wr_ptr] <= cmd_byte_en;
        end
    end

    // Issue FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign start_ok = !empty && init_complete && p0_ready;

    // Issue FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)  state_nxt = REQ;
            REQ:     if (!p0_ready) state_nxt = BUSY;
            BUSY:    if (p0_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue FSM: transition strobes driving the registered outputs
    always_comb begin
        issue = 1'b0;
        pop   = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    issue = start_ok;
            REQ:     pop   = !p0_ready;
            BUSY:    done  = p0_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p0_addr    <= '0;
            p0_data    <= '0;
            p0_byte_en <= '0;
            p0_wr_req  <= 1'b0;
            p0_rd_req  <= 1'b0;
            is_read    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (issue) begin
                p0_addr    <= fifo_addr[rd_ptr];
                p0_data    <= fifo_data[rd_ptr];
                p0_byte_en <= fifo_byte_en[rd_ptr];
                p0_wr_req  <= fifo_we[rd_ptr];
                p0_rd_req  <= !fifo_we[rd_ptr];
            end else if (pop) begin
                // Controller has taken the request; fields go quiet and we
                // remember whether a read response is owed.
                p0_addr    <= '0;
                p0_data    <= '0;
                p0_byte_en <= '0;
                p0_wr_req  <= 1'b0;
                p0_rd_req  <= 1'b0;
                is_read    <= p0_rd_req;
            end
            if (done && is_read) begin
                rsp_valid <= 1'b1;
                rsp_data  <= p0_q;
            end
        end
    end

endmodule
